// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM port arbiter: read-owner codes
// and the grant encoding used by the winner-select logic.
package ram_arb_pkg;

  localparam logic [1:0] OWNER_NONE = 2'd0;
  localparam logic [1:0] OWNER_A    = 2'd1;
  localparam logic [1:0] OWNER_B    = 2'd2;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_A    = 2'd1,
    GNT_B    = 2'd2
  } grant_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// One requester port of the RAM arbiter.
// master: req/we/addr/wdata out, ready/rvalid/rdata in; slave: mirror.
interface ram_port_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_SPACE = 16
);

  logic                  req;
  logic                  we;
  logic [ADDR_SPACE-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ready;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, rvalid, rdata
  );

endinterface

// File: rtl/ram_arb_grant.sv
// Combinational winner select: a_req, b_req, last_grant, starve -> gnt.
// Macro ARB_ROUND_ROBIN_EN selects round-robin; default is B-priority.
module ram_arb_grant
  import ram_arb_pkg::*;
(
  input  logic   a_req,
  input  logic   b_req,
  input  grant_t last_grant,
  input  logic   starve,
  output grant_t gnt
);

  logic a_wins;

`ifdef ARB_ROUND_ROBIN_EN
  logic unused_starve;
  assign unused_starve = starve;
  assign a_wins = (last_grant != GNT_A);
`else
  logic [1:0] unused_last;
  assign unused_last = last_grant;
  assign a_wins = starve;
`endif

  always_comb begin
    gnt = GNT_NONE;
    unique case (1'b1)
      (a_req && !b_req): gnt = GNT_A;
      (!a_req && b_req): gnt = GNT_B;
      (a_req && b_req):  gnt = a_wins ? GNT_A : GNT_B;
      default:           gnt = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-port front end for a 1-cycle single-port RAM (A=fetch, B=LSU).
// Ports: clock, reset, a/b (slave), ram_address/data/wren, ram_q. Macro: ARB_ROUND_ROBIN_EN.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_SPACE = 16,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  ram_port_arbiter_if.slave     a,
  ram_port_arbiter_if.slave     b,
  output logic [ADDR_SPACE-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  grant_t                gnt_raw;
  grant_t                gnt;
  grant_t                last_grant;
  logic [1:0]            rd_owner;
  logic [3:0]            wait_cnt;
  logic [ADDR_SPACE-1:0] addr_q;
  logic                  starve;

  ram_arb_grant u_grant (
    .a_req      (a.req),
    .b_req      (b.req),
    .last_grant (last_grant),
    .starve     (starve),
    .gnt        (gnt_raw)
  );

  assign gnt     = reset ? GNT_NONE : gnt_raw;
  assign a.ready = (gnt == GNT_A);
  assign b.ready = (gnt == GNT_B);

  // Address falls back to the last granted one when idle.
  always_comb begin
    ram_address = addr_q;
    ram_data    = '0;
    ram_wren    = 1'b0;
    unique case (1'b1)
      a.ready: begin
        ram_address = a.addr;
        ram_data    = a.wdata;
        ram_wren    = a.we;
      end
      b.ready: begin
        ram_address = b.addr;
        ram_data    = b.wdata;
        ram_wren    = b.we;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q     <= '0;
      rd_owner   <= OWNER_NONE;
      last_grant <= GNT_B;
    end else begin
      if (gnt != GNT_NONE) begin
        addr_q     <= ram_address;
        last_grant <= gnt;
      end
      rd_owner <= OWNER_NONE;
      if (a.ready && !a.we) rd_owner <= OWNER_A;
      if (b.ready && !b.we) rd_owner <= OWNER_B;
    end
  end

  // A read accepted just before reset must not surface.
  assign a.rvalid = (rd_owner == OWNER_A) && !reset;
  assign b.rvalid = (rd_owner == OWNER_B) && !reset;
  assign a.rdata  = ram_q;
  assign b.rdata  = ram_q;

`ifdef ARB_ROUND_ROBIN_EN
  logic unused_rr;
  assign starve    = 1'b0;
  assign wait_cnt  = 4'd0;
  assign unused_rr = ^{wait_cnt, 4'(MAX_WAIT)};
`else
  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  assign starve = (wait_cnt == WAIT_LIM);

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!a.req || a.ready) begin
      wait_cnt <= '0;
    end else if (!starve) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, per-cycle model check
// plus directed scenarios with literal expectations.
module tb_ram_port_arbiter;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int MW = 4;

  logic          clk;
  logic          rst;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data;
  logic          ram_wren;
  logic [DW-1:0] ram_q;

  ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_SPACE(AW)) a_if ();
  ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_SPACE(AW)) b_if ();

  ram_port_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_SPACE (AW),
    .MAX_WAIT   (MW)
  ) dut (
    .clock       (clk),
    .reset       (rst),
    .a           (a_if.slave),
    .b           (b_if.slave),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .ram_q       (ram_q)
  );

  // Single-port RAM with registered read.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  // Model state.
  bit            started = 0;
  logic [DW-1:0] mmem [256];
  bit            m_pa, m_pb;
  logic [DW-1:0] m_pd;
  logic [AW-1:0] m_addr;
  int            m_refused;
  bit            m_last_b;
  bit            ga, gb;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]  = '0;
      mmem[i] = '0;
    end
    m_pa = 0; m_pb = 0; m_pd = '0;
    m_addr = '0; m_refused = 0; m_last_b = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      ga = 0;
      gb = 0;
      if (!rst) begin
        if (a_if.req && !b_if.req) ga = 1;
        else if (!a_if.req && b_if.req) gb = 1;
        else if (a_if.req && b_if.req) begin
`ifdef ARB_ROUND_ROBIN_EN
          if (m_last_b) ga = 1; else gb = 1;
`else
          if (m_refused >= MW) ga = 1; else gb = 1;
`endif
        end
      end
      chk("m_a_ready", 32'(a_if.ready), 32'(ga));
      chk("m_b_ready", 32'(b_if.ready), 32'(gb));
      chk("m_a_rvalid", 32'(a_if.rvalid), 32'(m_pa && !rst));
      chk("m_b_rvalid", 32'(b_if.rvalid), 32'(m_pb && !rst));
      if (m_pa && !rst) chk("m_a_rdata", 32'(a_if.rdata), 32'(m_pd));
      if (m_pb && !rst) chk("m_b_rdata", 32'(b_if.rdata), 32'(m_pd));
      if (ga) begin
        chk("m_addr_a", 32'(ram_address), 32'(a_if.addr));
        chk("m_data_a", 32'(ram_data), 32'(a_if.wdata));
        chk("m_wren_a", 32'(ram_wren), 32'(a_if.we));
      end else if (gb) begin
        chk("m_addr_b", 32'(ram_address), 32'(b_if.addr));
        chk("m_data_b", 32'(ram_data), 32'(b_if.wdata));
        chk("m_wren_b", 32'(ram_wren), 32'(b_if.we));
      end else begin
        chk("m_addr_idle", 32'(ram_address), 32'(m_addr));
        chk("m_data_idle", 32'(ram_data), 32'd0);
        chk("m_wren_idle", 32'(ram_wren), 32'd0);
      end
      if (rst) begin
        m_pa = 0; m_pb = 0; m_refused = 0;
        m_last_b = 1; m_addr = '0;
      end else begin
        m_pa = ga && !a_if.we;
        m_pb = gb && !b_if.we;
        if (ga) begin
          m_addr = a_if.addr;
          m_pd = mmem[a_if.addr];
          if (a_if.we) mmem[a_if.addr] = a_if.wdata;
          m_last_b = 0;
        end
        if (gb) begin
          m_addr = b_if.addr;
          m_pd = mmem[b_if.addr];
          if (b_if.we) mmem[b_if.addr] = b_if.wdata;
          m_last_b = 1;
        end
        if (!a_if.req || ga) m_refused = 0;
        else m_refused++;
      end
    end
  end

  task automatic set_a(bit r, bit w, logic [AW-1:0] ad, logic [DW-1:0] d);
    a_if.req = r; a_if.we = w; a_if.addr = ad; a_if.wdata = d;
  endtask

  task automatic set_b(bit r, bit w, logic [AW-1:0] ad, logic [DW-1:0] d);
    b_if.req = r; b_if.we = w; b_if.addr = ad; b_if.wdata = d;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int  n;
  bit  got;

  initial begin
    rst = 1'b1;
    set_a(0, 0, '0, '0);
    set_b(0, 0, '0, '0);
    cyc();
    started = 1;
    cyc();
    rst = 1'b0;

`ifdef ARB_ROUND_ROBIN_EN
    // 4: alternating grants starting with A after reset.
    set_a(1, 0, 8'h03, '0);
    set_b(1, 0, 8'h04, '0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t4_a_turn", 32'(a_if.ready), 32'((i % 2) == 0));
      chk("t4_b_turn", 32'(b_if.ready), 32'((i % 2) == 1));
      cyc();
    end
    set_a(0, 0, '0, '0);
    set_b(0, 0, '0, '0);
    cyc();
`endif

    // 1: A write then A read of 0x10.
    set_a(1, 1, 8'h10, 16'hBEEF);
    @(negedge clk);
    chk("t1_wr_ready", 32'(a_if.ready), 32'd1);
    cyc();
    set_a(1, 0, 8'h10, '0);
    @(negedge clk);
    chk("t1_rd_ready", 32'(a_if.ready), 32'd1);
    cyc();
    set_a(0, 0, '0, '0);
    @(negedge clk);
    chk("t1_rvalid", 32'(a_if.rvalid), 32'd1);
    chk("t1_rdata", 32'(a_if.rdata), 32'hBEEF);
    chk("t1_b_rvalid", 32'(b_if.rvalid), 32'd0);
    cyc();
    @(negedge clk);
    chk("t1_rvalid_once", 32'(a_if.rvalid), 32'd0);

    // 2: conflicting reads, B first then A.
    cyc();
    set_a(1, 1, 8'h01, 16'h1111);
    cyc();
    set_a(1, 1, 8'h02, 16'h2222);
    cyc();
    set_a(1, 0, 8'h01, '0);
    set_b(1, 0, 8'h02, '0);
    @(negedge clk);
    chk("t2_b_first", 32'(b_if.ready), 32'd1);
    chk("t2_a_wait", 32'(a_if.ready), 32'd0);
    cyc();
    set_b(0, 0, '0, '0);
    @(negedge clk);
    chk("t2_a_next", 32'(a_if.ready), 32'd1);
    chk("t2_b_rvalid", 32'(b_if.rvalid), 32'd1);
    chk("t2_b_rdata", 32'(b_if.rdata), 32'h2222);
    cyc();
    set_a(0, 0, '0, '0);
    @(negedge clk);
    chk("t2_a_rvalid", 32'(a_if.rvalid), 32'd1);
    chk("t2_a_rdata", 32'(a_if.rdata), 32'h1111);
    chk("t2_b_quiet", 32'(b_if.rvalid), 32'd0);
    cyc();

`ifndef ARB_ROUND_ROBIN_EN
    // 3: starvation guard forces A after MAX_WAIT refusals.
    set_a(1, 0, 8'h10, '0);
    set_b(1, 0, 8'h20, '0);
    n = 0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (a_if.ready) got = 1;
      else begin
        n++;
        cyc();
      end
    end
    chk("t3_granted", 32'(got), 32'd1);
    chk("t3_refusals", 32'(n), 32'd4);
    cyc();
    set_a(0, 0, '0, '0);
    @(negedge clk);
    chk("t3_wait_cnt", 32'(dut.wait_cnt), 32'd0);
    cyc();
    set_b(0, 0, '0, '0);
    cyc();
`endif

    // 5: B write then A read of the same address.
    set_b(1, 1, 8'h20, 16'h1234);
    @(negedge clk);
    chk("t5_b_wr", 32'(b_if.ready), 32'd1);
    cyc();
    set_b(0, 0, '0, '0);
    set_a(1, 0, 8'h20, '0);
    @(negedge clk);
    chk("t5_a_rd", 32'(a_if.ready), 32'd1);
    cyc();
    set_a(0, 0, '0, '0);
    @(negedge clk);
    chk("t5_rvalid", 32'(a_if.rvalid), 32'd1);
    chk("t5_rdata", 32'(a_if.rdata), 32'h1234);
    cyc();

    // 6: reset rises right after an A read is accepted.
    set_a(1, 0, 8'h10, '0);
    @(negedge clk);
    chk("t6_acc", 32'(a_if.ready), 32'd1);
    cyc();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_a_ready", 32'(a_if.ready), 32'd0);
      chk("t6_a_rvalid", 32'(a_if.rvalid), 32'd0);
      chk("t6_b_rvalid", 32'(b_if.rvalid), 32'd0);
      chk("t6_wren", 32'(ram_wren), 32'd0);
      cyc();
    end
    rst = 1'b0;
    @(negedge clk);
    chk("t6_post_ready", 32'(a_if.ready), 32'd1);
    chk("t6_post_quiet", 32'(a_if.rvalid), 32'd0);
    cyc();
    set_a(0, 0, '0, '0);
    @(negedge clk);
    chk("t6_rvalid", 32'(a_if.rvalid), 32'd1);
    chk("t6_rdata", 32'(a_if.rdata), 32'hBEEF);
    cyc();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
